// File: rtl/pwm_pulse_decoder.sv
// rtl/pwm_pulse_decoder.sv - PWM pulse width/period decoder with short/long classification and fault strobes
// Measures in prescaled ticks; the tick on an edge cycle belongs to the interval that is ending.
module pwm_pulse_decoder #(
    parameter int TICK_DIV   = 2400,
    parameter int CW         = 8,
    parameter int SHORT_MAX  = 10,
    parameter int MAX_WIDTH  = 30,
    parameter int MIN_PERIOD = 100,
    parameter int MAX_PERIOD = 250
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          pwm_in_i,
    output logic [CW-1:0] width_o,
    output logic [CW-1:0] period_o,
    output logic          pulse_class_o,
    output logic          valid_o,
    output logic          width_err_o,
    output logic          period_err_o,
    output logic          sig_lost_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] SHORT_MAX_C  = CW'(SHORT_MAX);
    localparam logic [CW-1:0] MAX_WIDTH_C  = CW'(MAX_WIDTH);
    localparam logic [CW-1:0] MIN_PERIOD_C = CW'(MIN_PERIOD);
    localparam logic [CW-1:0] MAX_PERIOD_C = CW'(MAX_PERIOD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          s1_q, s2_q, s3_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] width_q, width_d;
    logic [CW-1:0] period_q, period_d;
    logic          class_q, class_d;
    logic          valid_q, valid_d;
    logic          werr_q, werr_d;
    logic          perr_q, perr_d;
    logic          lost_q, lost_d;

    logic          tick;
    logic          rise;
    logic          fall;
    logic [CW-1:0] wcnt_inc;
    logic [CW-1:0] pcnt_inc;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign tick     = (presc_q == PRESC_LAST);
    assign rise     = s2_q & ~s3_q;
    assign fall     = ~s2_q & s3_q;
    assign presc_d  = tick ? '0 : presc_q + 1'b1;
    // Counters already include this cycle's tick so an edge on a tick cycle credits the ending interval.
    assign wcnt_inc = tick ? sat_inc(wcnt_q) : wcnt_q;
    assign pcnt_inc = tick ? sat_inc(pcnt_q) : pcnt_q;

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        pcnt_d   = pcnt_q;
        width_d  = width_q;
        period_d = period_q;
        class_d  = class_q;
        valid_d  = 1'b0;
        werr_d   = 1'b0;
        perr_d   = 1'b0;
        lost_d   = lost_q;
        case (state_q)
            IDLE: begin
                wcnt_d = '0;
                pcnt_d = '0;
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                wcnt_d = wcnt_inc;
                pcnt_d = pcnt_inc;
                if (wcnt_inc > MAX_WIDTH_C) begin
                    werr_d  = 1'b1;
                    state_d = IDLE;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end else if (fall) begin
                    state_d = LOW;
                end
            end
            LOW: begin
                pcnt_d = pcnt_inc;
                if (rise) begin
                    if (pcnt_inc >= MIN_PERIOD_C) begin
                        width_d  = wcnt_q;
                        period_d = pcnt_inc;
                        class_d  = (wcnt_q > SHORT_MAX_C);
                        valid_d  = 1'b1;
                        lost_d   = 1'b0;
                    end else begin
                        perr_d = 1'b1;
                    end
                    state_d = HIGH;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end else if (pcnt_inc == MAX_PERIOD_C) begin
                    lost_d  = 1'b1;
                    state_d = IDLE;
                    wcnt_d  = '0;
                    pcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
                pcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
            presc_q  <= '0;
            wcnt_q   <= '0;
            pcnt_q   <= '0;
            width_q  <= '0;
            period_q <= '0;
            class_q  <= 1'b0;
            valid_q  <= 1'b0;
            werr_q   <= 1'b0;
            perr_q   <= 1'b0;
            lost_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            s1_q     <= pwm_in_i;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
            presc_q  <= presc_d;
            wcnt_q   <= wcnt_d;
            pcnt_q   <= pcnt_d;
            width_q  <= width_d;
            period_q <= period_d;
            class_q  <= class_d;
            valid_q  <= valid_d;
            werr_q   <= werr_d;
            perr_q   <= perr_d;
            lost_q   <= lost_d;
        end
    end

    assign width_o       = width_q;
    assign period_o      = period_q;
    assign pulse_class_o = class_q;
    assign valid_o       = valid_q;
    assign width_err_o   = werr_q;
    assign period_err_o  = perr_q;
    assign sig_lost_o    = lost_q;

endmodule

// File: tb/tb_pwm_pulse_decoder.sv
// tb/tb_pwm_pulse_decoder.sv - directed self-checking bench for pwm_pulse_decoder (TICK_DIV=4)
module tb_pwm_pulse_decoder;

    localparam int TD = 4;

    logic       clk;
    logic       rst_n;
    logic       pwm;
    logic [7:0] width_o;
    logic [7:0] period_o;
    logic       pulse_class_o;
    logic       valid_o;
    logic       width_err_o;
    logic       period_err_o;
    logic       sig_lost_o;

    int tests;
    int fails;
    int vcnt;
    int wecnt;
    int pecnt;

    pwm_pulse_decoder #(
        .TICK_DIV  (TD),
        .CW        (8),
        .SHORT_MAX (10),
        .MAX_WIDTH (30),
        .MIN_PERIOD(100),
        .MAX_PERIOD(250)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pwm_in_i     (pwm),
        .width_o      (width_o),
        .period_o     (period_o),
        .pulse_class_o(pulse_class_o),
        .valid_o      (valid_o),
        .width_err_o  (width_err_o),
        .period_err_o (period_err_o),
        .sig_lost_o   (sig_lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o) vcnt++;
        if (width_err_o) wecnt++;
        if (period_err_o) pecnt++;
    end

    task automatic send(input int h, input int p);
        pwm = 1'b1;
        repeat (h * TD) @(negedge clk);
        pwm = 1'b0;
        repeat ((p - h) * TD) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pwm   = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (width_o !== 8'd0) begin fails++; $display("FAIL rst_width got %0d expected 0", width_o); end
        tests++; if (period_o !== 8'd0) begin fails++; $display("FAIL rst_period got %0d expected 0", period_o); end
        tests++; if (pulse_class_o !== 1'b0) begin fails++; $display("FAIL rst_class got %0b expected 0", pulse_class_o); end
        tests++; if ({valid_o, width_err_o, period_err_o} !== 3'b000) begin fails++; $display("FAIL rst_strobes got %b expected 000", {valid_o, width_err_o, period_err_o}); end
        tests++; if (sig_lost_o !== 1'b1) begin fails++; $display("FAIL rst_sig_lost got %0b expected 1", sig_lost_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_short_train();
        int v0;
        v0 = vcnt;
        send(6, 200);
        tests++; if (vcnt !== v0) begin fails++; $display("FAIL t1_arm_valids got %0d expected %0d", vcnt, v0); end
        tests++; if (sig_lost_o !== 1'b1) begin fails++; $display("FAIL t1_arm_sig_lost got %0b expected 1", sig_lost_o); end
        send(6, 200);
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t1_valids got %0d expected %0d", vcnt, v0 + 1); end
        tests++; if (width_o !== 8'd6) begin fails++; $display("FAIL t1_width got %0d expected 6", width_o); end
        tests++; if (period_o !== 8'd200) begin fails++; $display("FAIL t1_period got %0d expected 200", period_o); end
        tests++; if (pulse_class_o !== 1'b0) begin fails++; $display("FAIL t1_class got %0b expected 0", pulse_class_o); end
        tests++; if (sig_lost_o !== 1'b0) begin fails++; $display("FAIL t1_sig_lost got %0b expected 0", sig_lost_o); end
        send(6, 200);
        tests++; if (vcnt !== v0 + 2) begin fails++; $display("FAIL t1_valids2 got %0d expected %0d", vcnt, v0 + 2); end
    endtask

    task automatic test_class_toggle();
        send(16, 200);
        send(6, 200);
        tests++; if (width_o !== 8'd16) begin fails++; $display("FAIL t2_width_long got %0d expected 16", width_o); end
        tests++; if (period_o !== 8'd200) begin fails++; $display("FAIL t2_period got %0d expected 200", period_o); end
        tests++; if (pulse_class_o !== 1'b1) begin fails++; $display("FAIL t2_class_long got %0b expected 1", pulse_class_o); end
        send(16, 200);
        tests++; if ({width_o, pulse_class_o} !== {8'd6, 1'b0}) begin fails++; $display("FAIL t2_toggle_short got w=%0d c=%0b expected w=6 c=0", width_o, pulse_class_o); end
        send(6, 200);
        tests++; if ({width_o, pulse_class_o} !== {8'd16, 1'b1}) begin fails++; $display("FAIL t2_toggle_long got w=%0d c=%0b expected w=16 c=1", width_o, pulse_class_o); end
    endtask

    task automatic test_width_fault();
        int v0;
        int we0;
        int n;
        v0  = vcnt;
        we0 = wecnt;
        n   = 0;
        pwm = 1'b1;
        while (n < 200 && !width_err_o) begin
            @(negedge clk);
            n++;
        end
        tests++; if (n < 123 || n > 128) begin fails++; $display("FAIL t3_werr_time got %0d cycles expected 124..127", n); end
        if (n < 160) repeat (160 - n) @(negedge clk);
        pwm = 1'b0;
        repeat (100) @(negedge clk);
        tests++; if (wecnt !== we0 + 1) begin fails++; $display("FAIL t3_werr_count got %0d expected %0d", wecnt, we0 + 1); end
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t3_valids got %0d expected %0d", vcnt, v0 + 1); end
        tests++; if (width_o !== 8'd6) begin fails++; $display("FAIL t3_width_held got %0d expected 6", width_o); end
        tests++; if (sig_lost_o !== 1'b0) begin fails++; $display("FAIL t3_sig_lost got %0b expected 0", sig_lost_o); end
        send(16, 200);
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t3_rearm_valids got %0d expected %0d", vcnt, v0 + 1); end
        send(6, 200);
        tests++; if (vcnt !== v0 + 2) begin fails++; $display("FAIL t3_recover_valids got %0d expected %0d", vcnt, v0 + 2); end
        tests++; if ({width_o, period_o, pulse_class_o} !== {8'd16, 8'd200, 1'b1}) begin fails++; $display("FAIL t3_recover got w=%0d p=%0d c=%0b expected w=16 p=200 c=1", width_o, period_o, pulse_class_o); end
    endtask

    task automatic test_period_fault();
        int v0;
        int pe0;
        send(6, 60);
        v0  = vcnt;
        pe0 = pecnt;
        send(16, 200);
        tests++; if (pecnt !== pe0 + 1) begin fails++; $display("FAIL t4_perr_count got %0d expected %0d", pecnt, pe0 + 1); end
        tests++; if (vcnt !== v0) begin fails++; $display("FAIL t4_no_valid got %0d expected %0d", vcnt, v0); end
        tests++; if ({width_o, period_o, pulse_class_o} !== {8'd6, 8'd200, 1'b0}) begin fails++; $display("FAIL t4_held got w=%0d p=%0d c=%0b expected w=6 p=200 c=0", width_o, period_o, pulse_class_o); end
        send(6, 200);
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t4_valid_after got %0d expected %0d", vcnt, v0 + 1); end
        tests++; if ({width_o, period_o, pulse_class_o} !== {8'd16, 8'd200, 1'b1}) begin fails++; $display("FAIL t4_after got w=%0d p=%0d c=%0b expected w=16 p=200 c=1", width_o, period_o, pulse_class_o); end
        tests++; if (pecnt !== pe0 + 1) begin fails++; $display("FAIL t4_perr_once got %0d expected %0d", pecnt, pe0 + 1); end
    endtask

    task automatic test_sig_lost();
        int v0;
        int we0;
        int pe0;
        int m;
        send(6, 200);
        v0  = vcnt;
        we0 = wecnt;
        pe0 = pecnt;
        m   = 0;
        while (m < 300 && !sig_lost_o) begin
            @(negedge clk);
            m++;
        end
        tests++; if (m < 199 || m > 204) begin fails++; $display("FAIL t5_lost_time got %0d cycles expected 200..203", m); end
        repeat (20) @(negedge clk);
        tests++; if ({vcnt, wecnt, pecnt} !== {v0, we0, pe0}) begin fails++; $display("FAIL t5_no_strobes got v=%0d w=%0d p=%0d expected v=%0d w=%0d p=%0d", vcnt, wecnt, pecnt, v0, we0, pe0); end
        send(6, 200);
        tests++; if (vcnt !== v0) begin fails++; $display("FAIL t5_arm_valids got %0d expected %0d", vcnt, v0); end
        tests++; if (sig_lost_o !== 1'b1) begin fails++; $display("FAIL t5_arm_sig_lost got %0b expected 1", sig_lost_o); end
        send(16, 200);
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t5_resume_valids got %0d expected %0d", vcnt, v0 + 1); end
        tests++; if ({width_o, period_o, sig_lost_o} !== {8'd6, 8'd200, 1'b0}) begin fails++; $display("FAIL t5_resume got w=%0d p=%0d l=%0b expected w=6 p=200 l=0", width_o, period_o, sig_lost_o); end
    endtask

    task automatic test_reset_and_coincidence();
        int v0;
        pwm = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if ({width_o, period_o, pulse_class_o} !== 17'd0) begin fails++; $display("FAIL t6_rst_high_vals got w=%0d p=%0d c=%0b expected 0", width_o, period_o, pulse_class_o); end
        tests++; if ({valid_o, width_err_o, period_err_o, sig_lost_o} !== 4'b0001) begin fails++; $display("FAIL t6_rst_high_flags got %b expected 0001", {valid_o, width_err_o, period_err_o, sig_lost_o}); end
        @(negedge clk);
        pwm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = vcnt;
        // Rises/falls below are placed so each is detected on a prescaler tick cycle.
        @(negedge clk);
        pwm = 1'b1;
        repeat (40) @(negedge clk);
        pwm = 1'b0;
        repeat (440) @(negedge clk);
        pwm = 1'b1;
        repeat (8) @(negedge clk);
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL t6_coinc_valids got %0d expected %0d", vcnt, v0 + 1); end
        tests++; if (width_o !== 8'd10) begin fails++; $display("FAIL t6_coinc_width got %0d expected 10", width_o); end
        tests++; if (period_o !== 8'd120) begin fails++; $display("FAIL t6_coinc_period got %0d expected 120", period_o); end
        tests++; if ({pulse_class_o, sig_lost_o} !== 2'b00) begin fails++; $display("FAIL t6_coinc_flags got %b expected 00", {pulse_class_o, sig_lost_o}); end
        repeat (32) @(negedge clk);
        pwm = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++; if ({width_o, period_o, pulse_class_o} !== 17'd0) begin fails++; $display("FAIL t6_rst_coinc_vals got w=%0d p=%0d c=%0b expected 0", width_o, period_o, pulse_class_o); end
        tests++; if ({valid_o, width_err_o, period_err_o, sig_lost_o} !== 4'b0001) begin fails++; $display("FAIL t6_rst_coinc_flags got %b expected 0001", {valid_o, width_err_o, period_err_o, sig_lost_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vcnt  = 0;
        wecnt = 0;
        pecnt = 0;
        rst_n = 1'b0;
        pwm   = 1'b0;
        @(negedge clk);
        test_reset();
        test_short_train();
        test_class_toggle();
        test_width_fault();
        test_period_fault();
        test_sig_lost();
        test_reset_and_coincidence();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
